// File: rtl/crack_arbiter.sv
// Arbiter for four key-search cores: holds them in reset, times the search,
// latches the first winning key (lowest core index) or flags total failure.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HOLD   | cores held in reset for RST_CYCLES cycles
// ST_SEARCH | cores running; elapsed counting, failures accumulating
// ST_FOUND  | winner latched, cores stopped (terminal until reset)
// ST_FAILED | every core exhausted its keyspace, cores stopped (terminal)
module crack_arbiter #(
  parameter int RST_CYCLES = 4,
  parameter int BLINK_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  success,
  input  logic [3:0]  total_failure,
  input  logic [23:0] secret_key0,
  input  logic [23:0] secret_key1,
  input  logic [23:0] secret_key2,
  input  logic [23:0] secret_key3,
  output logic        core_reset_n,
  output logic        stop,
  output logic        found,
  output logic        all_failed,
  output logic [1:0]  winner_id,
  output logic [23:0] found_key,
  output logic [31:0] elapsed,
  output logic [9:0]  LEDR
);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_FOUND  = 2'd2;
  localparam logic [1:0] ST_FAILED = 2'd3;

  localparam logic [7:0]  HOLD_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [31:0] ELAPSED_MAX = 32'hFFFF_FFFF;

  logic [1:0]            state_q, state_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [31:0]           elapsed_q, elapsed_d;
  logic [3:0]            fail_seen_q, fail_seen_d;
  logic [1:0]            winner_q, winner_d;
  logic [23:0]           key_q, key_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  core_reset_n_q, core_reset_n_d;
  logic                  stop_q, stop_d;
  logic                  found_q, found_d;
  logic                  all_failed_q, all_failed_d;

  logic [1:0]  win_idx;
  logic [23:0] win_key;
  logic [3:0]  fail_all;
  logic        blink_msb;
  logic [3:0]  winner_onehot;

  // Lowest-index success wins; scanning downward lets the lowest overwrite.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (success[i]) win_idx = 2'(i);
    end
    case (win_idx)
      2'd0:    win_key = secret_key0;
      2'd1:    win_key = secret_key1;
      2'd2:    win_key = secret_key2;
      default: win_key = secret_key3;
    endcase
  end

  assign fail_all = fail_seen_q | total_failure;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    elapsed_d   = elapsed_q;
    fail_seen_d = fail_seen_q;
    winner_d    = winner_q;
    key_d       = key_q;
    blink_d     = blink_q + 1'b1;

    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        // The edge leaving SEARCH still counts that final cycle.
        if (elapsed_q != ELAPSED_MAX) elapsed_d = elapsed_q + 32'd1;
        fail_seen_d = fail_all;
        if (|success) begin
          state_d  = ST_FOUND;
          winner_d = win_idx;
          key_d    = win_key;
        end else if (fail_all == 4'hF) begin
          state_d = ST_FAILED;
        end
      end
      default: ;
    endcase

    // Status outputs decode the next state so they flip on the entering edge.
    core_reset_n_d = (state_d != ST_HOLD);
    stop_d         = (state_d == ST_FOUND) || (state_d == ST_FAILED);
    found_d        = (state_d == ST_FOUND);
    all_failed_d   = (state_d == ST_FAILED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      elapsed_q      <= '0;
      fail_seen_q    <= '0;
      winner_q       <= '0;
      key_q          <= '0;
      blink_q        <= '0;
      core_reset_n_q <= 1'b0;
      stop_q         <= 1'b0;
      found_q        <= 1'b0;
      all_failed_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      elapsed_q      <= elapsed_d;
      fail_seen_q    <= fail_seen_d;
      winner_q       <= winner_d;
      key_q          <= key_d;
      blink_q        <= blink_d;
      core_reset_n_q <= core_reset_n_d;
      stop_q         <= stop_d;
      found_q        <= found_d;
      all_failed_q   <= all_failed_d;
    end
  end

  assign blink_msb     = blink_q[BLINK_BITS-1];
  assign winner_onehot = 4'b0001 << winner_q;

  always_comb begin
    case (state_q)
      ST_SEARCH: LEDR = {5'b00000, fail_seen_q, blink_msb};
      ST_FOUND:  LEDR = {1'b1, winner_onehot, 5'b00000};
      ST_FAILED: LEDR = {10{blink_msb}};
      default:   LEDR = 10'd0;
    endcase
  end

  assign core_reset_n = core_reset_n_q;
  assign stop         = stop_q;
  assign found        = found_q;
  assign all_failed   = all_failed_q;
  assign winner_id    = winner_q;
  assign found_key    = key_q;
  assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_crack_arbiter.sv
// Randomized and directed bench for crack_arbiter against a cycle-level
// behavioural model of the search/hold/terminal rules.
module tb_crack_arbiter;

  localparam int RST_CYCLES = 4;
  localparam int BB         = 5;

  localparam int M_HOLD   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_FOUND  = 2;
  localparam int M_FAILED = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  succ;
  logic [3:0]  tf;
  logic [23:0] key_in [4];
  logic        core_reset_n, stop, found, all_failed;
  logic [1:0]  winner_id;
  logic [23:0] found_key;
  logic [31:0] elapsed;
  logic [9:0]  LEDR;

  int n_checks = 0;
  int n_errors = 0;

  int              m_st;
  int              m_hold;
  longint unsigned m_el;
  logic [3:0]      m_seen;
  int              m_win;
  logic [23:0]     m_key;
  int unsigned     m_blink;

  crack_arbiter #(.RST_CYCLES(RST_CYCLES), .BLINK_BITS(BB)) dut (
    .clk(clk), .reset(rst), .success(succ), .total_failure(tf),
    .secret_key0(key_in[0]), .secret_key1(key_in[1]),
    .secret_key2(key_in[2]), .secret_key3(key_in[3]),
    .core_reset_n(core_reset_n), .stop(stop), .found(found),
    .all_failed(all_failed), .winner_id(winner_id), .found_key(found_key),
    .elapsed(elapsed), .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_led();
    logic msb;
    msb = ((m_blink >> (BB - 1)) & 1) != 0;
    case (m_st)
      M_SEARCH: return 10'(m_seen) * 2 + 10'(msb);
      M_FOUND:  return 10'd512 + (10'd32 << m_win);
      M_FAILED: return msb ? 10'h3FF : 10'h000;
      default:  return 10'h000;
    endcase
  endfunction

  task automatic model_update();
    if (rst) begin
      m_st = M_HOLD; m_hold = 0; m_el = 0; m_seen = 4'h0;
      m_win = 0; m_key = 24'h0; m_blink = 0;
    end else begin
      m_blink = (m_blink + 1) % (1 << BB);
      case (m_st)
        M_HOLD: begin
          m_hold++;
          if (m_hold == RST_CYCLES) m_st = M_SEARCH;
        end
        M_SEARCH: begin
          if (m_el < 64'hFFFF_FFFF) m_el++;
          m_seen = m_seen | tf;
          if (succ != 4'h0) begin
            for (int i = 3; i >= 0; i--) if (succ[i]) m_win = i;
            m_key = key_in[m_win];
            m_st = M_FOUND;
          end else if (m_seen == 4'hF) begin
            m_st = M_FAILED;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_eq("core_reset_n", core_reset_n, (m_st != M_HOLD));
    check_eq("stop", stop, (m_st == M_FOUND || m_st == M_FAILED));
    check_eq("found", found, (m_st == M_FOUND));
    check_eq("all_failed", all_failed, (m_st == M_FAILED));
    check_eq("winner_id", winner_id, m_win);
    check_eq("found_key", found_key, m_key);
    check_eq("elapsed", elapsed, m_el);
    check_eq("LEDR", LEDR, exp_led());
  endtask

  task automatic rand_keys();
    for (int i = 0; i < 4; i++) key_in[i] = 24'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; succ = 4'h0; tf = 4'h0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  // Walk through HOLD with garbage on the inputs; they must be ignored.
  task automatic pass_hold();
    int guard = 0;
    while (m_st == M_HOLD && guard < 300) begin
      succ = 4'($urandom); tf = 4'($urandom); rand_keys();
      step();
      guard++;
    end
    check_eq("hold_exit", (m_st == M_SEARCH), 1);
    succ = 4'h0; tf = 4'h0;
  endtask

  task automatic idle(input int n);
    succ = 4'h0; tf = 4'h0;
    repeat (n) step();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; succ = 4'h0; tf = 4'h0;
    for (int i = 0; i < 4; i++) key_in[i] = 24'h0;

    // Reset state and 100-cycle search with core 2 winning.
    do_reset(3);
    check_eq("rst_found_key", found_key, 24'h0);
    cnt = 0;
    while (core_reset_n == 1'b0 && cnt < 50) begin
      succ = 4'($urandom); tf = 4'($urandom);
      step(); cnt++;
    end
    check_eq("hold_len", cnt, RST_CYCLES);
    check_eq("first_elapsed", elapsed, 0);
    succ = 4'h0; tf = 4'h0;
    idle(99);
    key_in[2] = 24'h0249F0; succ = 4'b0100;
    step();
    check_eq("d033_found", found, 1);
    check_eq("d033_stop", stop, 1);
    check_eq("d033_win", winner_id, 2);
    check_eq("d033_key", found_key, 24'h0249F0);
    check_eq("d033_elapsed", elapsed, 100);
    check_eq("d033_led", LEDR, 10'b1010000000);
    repeat (6) begin succ = 4'($urandom); tf = 4'($urandom); rand_keys(); step(); end
    check_eq("d033_frozen_el", elapsed, 100);

    // Two simultaneous successes: lowest index wins.
    do_reset(1); pass_hold(); idle(10);
    rand_keys(); succ = 4'b1010;
    step();
    check_eq("d034_win", winner_id, 1);
    check_eq("d034_key", found_key, key_in[1]);
    idle(3);

    // Failures accumulated one core at a time.
    do_reset(2); pass_hold(); idle(3);
    tf = 4'b0001; step(); idle(3);
    tf = 4'b0010; step(); idle(2);
    tf = 4'b0100; step(); idle(1);
    check_eq("d035_not_yet", all_failed, 0);
    tf = 4'b1000; step();
    check_eq("d035_allf", all_failed, 1);
    check_eq("d035_stop", stop, 1);
    check_eq("d035_found", found, 0);
    check_eq("d035_key", found_key, 24'h0);
    repeat (40) begin succ = 4'($urandom); tf = 4'($urandom); step(); end

    // Success beats simultaneous total failure.
    do_reset(1); pass_hold(); idle(7);
    rand_keys(); tf = 4'hF; succ = 4'b1000;
    step();
    check_eq("d036_found", found, 1);
    check_eq("d036_win", winner_id, 3);
    check_eq("d036_allf", all_failed, 0);
    idle(2);

    // Reset out of FOUND restarts the whole sequence.
    do_reset(1);
    check_eq("d037_found", found, 0);
    check_eq("d037_stop", stop, 0);
    check_eq("d037_key", found_key, 24'h0);
    check_eq("d037_crn", core_reset_n, 0);
    cnt = 0;
    while (core_reset_n == 1'b0 && cnt < 50) begin step(); cnt++; end
    check_eq("d037_hold_len", cnt, RST_CYCLES);
    idle(5);
    rand_keys(); succ = 4'b0001; step();
    check_eq("d037_found2", found, 1);
    check_eq("d037_win2", winner_id, 0);
    check_eq("d037_key2", found_key, key_in[0]);
    check_eq("d037_el2", elapsed, 6);

    // Randomized episodes, including resets mid-run.
    for (int ep = 0; ep < 40; ep++) begin
      int len;
      int srate;
      do_reset(1 + int'($urandom % 3));
      pass_hold();
      len   = int'($urandom_range(400, 20));
      srate = (ep % 2 == 0) ? 40 : 400;
      for (int c = 0; c < len; c++) begin
        rst  = ($urandom % 300 == 0);
        succ = ($urandom % srate == 0) ? 4'($urandom) : 4'h0;
        tf   = ($urandom % 20 == 0) ? 4'(1 << ($urandom % 4)) : 4'h0;
        rand_keys();
        step();
      end
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crack_arbiter.md
CRACK_ARBITER -- requirements
Module: crack_arbiter

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4, meaning the number of cycles core_reset_n is held low after reset (range 1..255).
REQ-002 SHALL have parameter BLINK_BITS, default 24, meaning the width of the free-running blink counter; its MSB drives blinking LEDs.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port success, input, 4, per-core success level; bit i comes from core i.
REQ-006 SHALL have port total_failure, input, 4, per-core keyspace-exhausted level.
REQ-007 SHALL have port secret_key0..secret_key3, input, 24 each, current key of core i.
REQ-008 SHALL have port core_reset_n, output, 1, shared active-low reset to all four cores.
REQ-009 SHALL have port stop, output, 1, shared halt to all four cores.
REQ-010 SHALL have port found, output, 1, a winning key is latched.
REQ-011 SHALL have port all_failed, output, 1, every core exhausted its keyspace without success.
REQ-012 SHALL have port winner_id, output, 2, index of the winning core.
REQ-013 SHALL have port found_key, output, 24, the latched winning key.
REQ-014 SHALL have port elapsed, output, 32, cycles spent in SEARCH.
REQ-015 SHALL have port LEDR, output, 10, status LEDs.

Function
REQ-016 SHALL implement FSM states HOLD, SEARCH, FOUND, FAILED; reset enters HOLD.
REQ-017 HOLD: core_reset_n=0, stop=0; hold counter increments each cycle; after exactly RST_CYCLES cycles in HOLD -> SEARCH.
REQ-018 SEARCH: core_reset_n=1, stop=0; elapsed increments by 1 each cycle, saturating at 0xFFFFFFFF.
REQ-019 SEARCH: per-core sticky flag fail_seen[i] sets when total_failure[i]=1 and clears only on reset.
REQ-020 SEARCH: if any success bit is 1 -> FOUND next cycle; winner = lowest index i with success[i]=1; found_key <= secret_key of that core and winner_id <= i on the same edge.
REQ-021 SEARCH: success from a core whose fail_seen is set is still honoured.
REQ-022 SEARCH: if no success and (fail_seen | total_failure) == 4'hF -> FAILED; success takes priority when both occur on the same cycle.
REQ-023 FOUND: stop=1, found=1, core_reset_n=1; found_key, winner_id, elapsed frozen; terminal until reset.
REQ-024 FAILED: stop=1, all_failed=1, core_reset_n=1; elapsed frozen; found_key stays 0; terminal until reset.
REQ-025 Outputs stop, found, all_failed, core_reset_n SHALL be registered, i.e. change on the clock edge that enters the new state, with no combinational path from inputs.
REQ-026 Inputs arriving in HOLD, FOUND or FAILED SHALL be ignored.
REQ-027 Blink counter SHALL free-run in all states, wrapping modulo 2^BLINK_BITS.
REQ-028 LEDR: HOLD -> all 0; SEARCH -> LEDR[0]=blink MSB, LEDR[4:1]=fail_seen; FOUND -> LEDR[9]=1, LEDR[8:5] one-hot of winner_id, rest 0; FAILED -> LEDR[9:0] all = blink MSB.

Reset
REQ-029 On reset=1 at a clock edge: state=HOLD, core_reset_n=0, stop=0, found=0, all_failed=0, winner_id=0, found_key=0, elapsed=0, fail_seen=0, hold and blink counters=0, LEDR=0.
REQ-030 Reset asserted mid-SEARCH, FOUND or FAILED SHALL abort immediately and re-run the full HOLD sequence, restarting all four cores.
REQ-031 Reset held for multiple cycles SHALL keep core_reset_n=0 throughout; HOLD counting starts on the first cycle with reset=0.

Verification
REQ-032 Reset, RST_CYCLES=4 -> core_reset_n low for 4 cycles after reset release, then high; state SEARCH; elapsed=0 on the first SEARCH cycle.
REQ-033 After 100 SEARCH cycles, success=4'b0100 with secret_key2=24'h0249F0 -> next edge: found=1, stop=1, winner_id=2, found_key=24'h0249F0, elapsed=100, LEDR=10'b1010000000.
REQ-034 success=4'b1010 simultaneously -> winner_id=1, found_key=secret_key1.
REQ-035 Pulse total_failure bits 0,1,2 in separate cycles, then bit 3 -> all_failed=1 and stop=1 one cycle after bit 3; found=0.
REQ-036 total_failure=4'hF and success=4'b1000 on the same cycle -> found=1, winner_id=3, all_failed=0.
REQ-037 Reset during FOUND -> found, stop and found_key clear; core_reset_n low for RST_CYCLES cycles; a new search completes normally.
